// File: rtl/task_ctrl_fsm_param.sv
// Top-level control FSM for a dataflow kernel of NUM_TASKS child tasks: host handshake,
// scalar broadcast, per-child start/done tracking, task mask, done delay and run watchdog.
module task_ctrl_fsm_param #(
    parameter int unsigned NUM_TASKS   = 6,
    parameter int unsigned SCALAR_W    = 64,
    parameter int unsigned NUM_SCALARS = 3,
    parameter int unsigned DELAY_W     = 4,
    parameter int unsigned TIMEOUT_W   = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            ap_start,
    output logic                            ap_ready,
    output logic                            ap_done,
    output logic                            ap_idle,
    output logic                            ap_err,
    input  logic [NUM_SCALARS*SCALAR_W-1:0] scalars,
    input  logic [NUM_TASKS-1:0]            task_en,
    input  logic [DELAY_W-1:0]              done_delay,
    input  logic [TIMEOUT_W-1:0]            timeout_limit,
    output logic [NUM_SCALARS*SCALAR_W-1:0] task_scalars,
    output logic [NUM_TASKS-1:0]            task_ap_start,
    input  logic [NUM_TASKS-1:0]            task_ap_ready,
    input  logic [NUM_TASKS-1:0]            task_ap_done,
    input  logic [NUM_TASKS-1:0]            task_ap_idle
);

    localparam int unsigned SCALARS_W = NUM_SCALARS * SCALAR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_START = 2'b01;
    localparam logic [1:0] C_RUN   = 2'b11;
    localparam logic [1:0] C_DONE  = 2'b10;

    logic [1:0]           state_q, state_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [DELAY_W-1:0]   delay_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [SCALARS_W-1:0] scalars_q;
    logic                 err_q, err_d;
    logic                 done_q, idle_q;
    logic [1:0]           child_q [NUM_TASKS];
    logic [1:0]           child_d [NUM_TASKS];

    logic start_acc;
    logic all_done;
    logic wd_hit;
    logic abort;

    // Child idle is a monitor-only input and deliberately has no effect on control.
    logic unused_idle;
    assign unused_idle = &{1'b0, task_ap_idle};

    assign start_acc = (state_q == S_IDLE) && ap_start;
    assign wd_hit    = (limit_q != '0) && (wd_q == limit_q - TIMEOUT_W'(1));

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (child_q[i] != C_DONE) begin
                all_done = 1'b0;
            end
        end
    end

    // Top FSM next-state; watchdog expiry takes priority over all-done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                    wd_d    = '0;
                end
            end
            S_RUN: begin
                wd_d = (&wd_q) ? wd_q : wd_q + TIMEOUT_W'(1);
                if (wd_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    abort   = 1'b1;
                end else if (all_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = delay_q;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-child next-state; an abort or the top DONE state returns every child to idle.
    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            child_d[i] = child_q[i];
            case (child_q[i])
                C_IDLE: begin
                    if (start_acc) begin
                        child_d[i] = task_en[i] ? C_START : C_DONE;
                    end
                end
                C_START: begin
                    if (task_ap_ready[i]) begin
                        child_d[i] = task_ap_done[i] ? C_DONE : C_RUN;
                    end
                end
                C_RUN: begin
                    if (task_ap_done[i]) begin
                        child_d[i] = C_DONE;
                    end
                end
                default: begin
                    child_d[i] = child_q[i];
                end
            endcase
            if (abort || (state_q == S_DONE)) begin
                child_d[i] = C_IDLE;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
            delay_q   <= '0;
            limit_q   <= '0;
            scalars_q <= '0;
            for (int i = 0; i < NUM_TASKS; i++) begin
                child_q[i] <= C_IDLE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            done_q  <= (state_d == S_DONE);
            idle_q  <= (state_d == S_IDLE);
            if (start_acc) begin
                delay_q   <= done_delay;
                limit_q   <= timeout_limit;
                scalars_q <= scalars;
            end
            for (int i = 0; i < NUM_TASKS; i++) begin
                child_q[i] <= child_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            task_ap_start[i] = (child_q[i] == C_START);
        end
    end

    assign ap_done      = done_q;
    assign ap_ready     = done_q;
    assign ap_idle      = idle_q;
    assign ap_err       = err_q;
    assign task_scalars = scalars_q;

endmodule

// File: tb/tb_task_ctrl_fsm_param.sv
// Self-checking bench for task_ctrl_fsm_param: modelled children respond to starts,
// expected completions are queued at start and checked when ap_done appears.
module tb_task_ctrl_fsm_param;

    localparam int unsigned NT = 6;
    localparam int unsigned SW = 64;
    localparam int unsigned NS = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned TW = 32;
    localparam int unsigned AW = NS * SW;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_err;
    logic [AW-1:0] scalars;
    logic [NT-1:0] task_en;
    logic [DW-1:0] done_delay;
    logic [TW-1:0] timeout_limit;
    logic [AW-1:0] task_scalars;
    logic [NT-1:0] task_ap_start;
    logic [NT-1:0] task_ap_ready;
    logic [NT-1:0] task_ap_done;
    logic [NT-1:0] task_ap_idle;

    typedef struct {
        int            cyc;
        logic          err;
        logic [AW-1:0] scal;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Child model: lat = cycles from ready to done (0 = same cycle, <0 = never done).
    int   lat       [NT];
    int   pend      [NT];
    int   start_cnt [NT];
    logic prev_start[NT];

    task_ctrl_fsm_param dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_err        (ap_err),
        .scalars       (scalars),
        .task_en       (task_en),
        .done_delay    (done_delay),
        .timeout_limit (timeout_limit),
        .task_scalars  (task_scalars),
        .task_ap_start (task_ap_start),
        .task_ap_ready (task_ap_ready),
        .task_ap_done  (task_ap_done),
        .task_ap_idle  (task_ap_idle)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        for (int i = 0; i < NT; i++) begin
            task_ap_ready[i] = 1'b0;
            task_ap_done[i]  = 1'b0;
            if (!ap_rst_n) begin
                pend[i] = 0;
            end else if (task_ap_start[i] === 1'b1) begin
                task_ap_ready[i] = 1'b1;
                if (!prev_start[i]) start_cnt[i] = start_cnt[i] + 1;
                if (lat[i] == 0) task_ap_done[i] = 1'b1;
                pend[i] = (lat[i] > 0) ? lat[i] : 0;
            end else if (pend[i] > 0) begin
                pend[i] = pend[i] - 1;
                if (pend[i] == 0) task_ap_done[i] = 1'b1;
            end
            prev_start[i] = (task_ap_start[i] === 1'b1);
        end
    end

    function automatic logic [AW-1:0] rand_scal();
        logic [AW-1:0] r;
        r = '0;
        for (int k = 0; k < AW / 32; k++) r = (r << 32) | AW'($urandom);
        return r;
    endfunction

    task automatic set_lat_all(input int v);
        for (int i = 0; i < NT; i++) lat[i] = v;
    endtask

    task automatic clear_start_cnt();
        for (int i = 0; i < NT; i++) start_cnt[i] = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    // Drives one start at the current negedge and queues its expected completion.
    task automatic launch(input logic [NT-1:0] en, input int dly, input int lim,
                          input int done_off, input logic err, output logic [AW-1:0] s);
        s             = rand_scal();
        scalars       = s;
        task_en       = en;
        done_delay    = DW'(dly);
        timeout_limit = TW'(lim);
        ap_start      = 1'b1;
        sb.push_back('{cyc: cyc + done_off, err: err, scal: s});
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        n_checks++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_ap_done: got %b want 0", ap_done); end
        n_checks++; if (ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ap_ready: got %b want 0", ap_ready); end
        n_checks++; if (ap_err !== 1'b0) begin n_fail++; $display("FAIL reset_ap_err: got %b want 0", ap_err); end
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_ap_idle: got %b want 1", ap_idle); end
        n_checks++; if (task_ap_start !== '0) begin n_fail++; $display("FAIL reset_task_start: got %h want 0", task_ap_start); end
        n_checks++; if (task_scalars !== '0) begin n_fail++; $display("FAIL reset_task_scalars: got %h want 0", task_scalars); end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        logic [AW-1:0] s;
        exp_t e;
        bit   seen;
        int   at;
        set_lat_all(0);
        launch(6'h3F, 0, 0, 4, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        n_checks++; if (task_ap_start !== 6'h3F) begin n_fail++; $display("FAIL basic_start: got %h want 3f", task_ap_start); end
        n_checks++; if (task_scalars !== s) begin n_fail++; $display("FAIL basic_scalars: got %h want %h", task_scalars, s); end
        wait_done(20, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", at, e.cyc); end
        n_checks++; if (ap_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", ap_ready); end
        n_checks++; if (ap_err !== e.err) begin n_fail++; $display("FAIL basic_err: got %b want %b", ap_err, e.err); end
        @(negedge ap_clk);
        n_checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin n_fail++; $display("FAIL basic_after: got idle=%b done=%b want idle=1 done=0", ap_idle, ap_done); end
    endtask

    task automatic test_staggered();
        logic [AW-1:0] s;
        exp_t e;
        bit   seen;
        int   at;
        set_lat_all(0);
        lat[3] = 50;
        clear_start_cnt();
        // child3 done level at start+1+50; ap_done follows 3+done_delay cycles later
        launch(6'h3F, 3, 0, 1 + 50 + 3 + 3, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_done(100, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL stagger_done_cycle: got %0d want %0d", at, e.cyc); end
        for (int i = 0; i < NT; i++) begin
            n_checks++; if (start_cnt[i] != 1) begin n_fail++; $display("FAIL stagger_start_count[%0d]: got %0d want 1", i, start_cnt[i]); end
        end
        @(negedge ap_clk);
    endtask

    task automatic test_mask();
        logic [AW-1:0] s;
        exp_t e;
        bit   seen;
        int   at;
        set_lat_all(-1);
        lat[0] = 2;
        lat[2] = 2;
        clear_start_cnt();
        launch(6'b000101, 1, 0, 1 + 2 + 3 + 1, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        n_checks++; if (task_ap_start !== 6'b000101) begin n_fail++; $display("FAIL mask_start: got %b want 000101", task_ap_start); end
        wait_done(40, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL mask_done_cycle: got %0d want %0d", at, e.cyc); end
        n_checks++; if (start_cnt[1] + start_cnt[3] + start_cnt[4] + start_cnt[5] != 0) begin n_fail++; $display("FAIL mask_disabled_started: got %0d want 0", start_cnt[1] + start_cnt[3] + start_cnt[4] + start_cnt[5]); end
        @(negedge ap_clk);
        // empty mask: completion at start+3+done_delay
        launch(6'b000000, 2, 0, 3 + 2, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        n_checks++; if (task_ap_start !== '0) begin n_fail++; $display("FAIL mask0_start: got %b want 0", task_ap_start); end
        wait_done(40, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL mask0_done_cycle: got %0d want %0d", at, e.cyc); end
        @(negedge ap_clk);
    endtask

    task automatic test_timeout();
        logic [AW-1:0] s;
        exp_t e;
        bit   seen;
        int   at;
        set_lat_all(0);
        lat[1] = -1;
        launch(6'h3F, 0, 20, 1 + 20, 1'b1, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_done(60, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d want %0d", at, e.cyc); end
        n_checks++; if (ap_err !== e.err) begin n_fail++; $display("FAIL timeout_err: got %b want %b", ap_err, e.err); end
        n_checks++; if (task_ap_start !== '0) begin n_fail++; $display("FAIL timeout_start_drop: got %h want 0", task_ap_start); end
        @(negedge ap_clk);
        n_checks++; if (ap_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", ap_err); end
        set_lat_all(0);
        launch(6'h3F, 0, 0, 4, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        n_checks++; if (ap_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b want 0", ap_err); end
        n_checks++; if (task_ap_start !== 6'h3F) begin n_fail++; $display("FAIL timeout_restart: got %h want 3f", task_ap_start); end
        wait_done(20, seen, at);
        e = sb.pop_front();
        n_checks++; if (!seen || at != e.cyc || ap_err !== e.err) begin n_fail++; $display("FAIL timeout_rerun: got cyc=%0d err=%b want cyc=%0d err=%b", at, ap_err, e.cyc, e.err); end
        @(negedge ap_clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [AW-1:0] s;
        int   pushed = 0;
        int   popped = 0;
        set_lat_all(0);
        task_en       = 6'h3F;
        done_delay    = '0;
        timeout_limit = '0;
        for (int k = 0; k < 100 && popped < 4; k++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_done: got done at %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc || task_scalars !== e.scal) begin
                        n_fail++; $display("FAIL b2b_run%0d: got cyc=%0d scal=%h want cyc=%0d scal=%h", popped, cyc, task_scalars, e.cyc, e.scal);
                    end
                end
                popped++;
            end
            s = rand_scal();
            scalars = s;
            if (ap_idle === 1'b1) begin
                if (pushed < 4) begin
                    ap_start = 1'b1;
                    sb.push_back('{cyc: cyc + 4, err: 1'b0, scal: s});
                    pushed++;
                end else begin
                    ap_start = 1'b0;
                end
            end
        end
        ap_start = 1'b0;
        n_checks++; if (popped != 4) begin n_fail++; $display("FAIL b2b_timeout: got %0d runs want 4", popped); end
        repeat (3) @(negedge ap_clk);
        sb.delete();
    endtask

    task automatic test_reset_midrun();
        logic [AW-1:0] s;
        bit   stray = 1'b0;
        set_lat_all(-1);
        launch(6'h3F, 0, 0, 0, 1'b0, s);
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (5) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b want 1", ap_idle); end
        n_checks++; if (task_ap_start !== '0) begin n_fail++; $display("FAIL midrst_start: got %h want 0", task_ap_start); end
        n_checks++; if (ap_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", ap_err); end
        for (int k = 0; k < 10; k++) begin
            if (ap_done !== 1'b0) stray = 1'b1;
            @(negedge ap_clk);
        end
        n_checks++; if (stray) begin n_fail++; $display("FAIL midrst_no_done: got done pulse want none"); end
        sb.delete();
        set_lat_all(0);
    endtask

    initial begin
        ap_rst_n      = 1'b0;
        ap_start      = 1'b0;
        scalars       = '0;
        task_en       = '0;
        done_delay    = '0;
        timeout_limit = '0;
        task_ap_idle  = '1;
        task_ap_ready = '0;
        task_ap_done  = '0;
        for (int i = 0; i < NT; i++) begin
            lat[i]        = 0;
            pend[i]       = 0;
            start_cnt[i]  = 0;
            prev_start[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_staggered();
        test_mask();
        test_timeout();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
